// File: rtl/uart_tx_fifo.sv
// Byte-serial 8N1/8N2 UART transmitter, LSB first, fed by a small valid/ready FIFO.
// Bit timing comes from an internal divider that restarts at every frame start.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             txd,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STOP_BITS * CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * CLK_DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [2:0]      idx_r, idx_s;
  logic [7:0]      shift_r, shift_s;
  logic            txd_r, txd_s;
  logic            busy_r;
  logic            ready_r;
  logic [LW-1:0]   level_r, level_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic            push_s, pop_s;

  assign tx_ready   = ready_r;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

  // Next-state, pop decision and next serial bit; a pop always loads the shifter and starts a frame.
  always_comb begin
    push_s  = tx_valid & ready_r;
    pop_s   = 1'b0;
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    case (state_r)
      IDLE: begin
        if (level_r != '0) begin
          pop_s   = 1'b1;
          state_s = START;
          cnt_s   = '0;
          shift_s = mem_r[rd_ptr_r];
          txd_s   = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      START: begin
        if (cnt_r == BIT_LAST) begin
          state_s = DATA;
          cnt_s   = '0;
          idx_s   = 3'd0;
          txd_s   = shift_r[0];
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s = '0;
          if (idx_r == 3'd7) begin
            state_s = STOP;
            txd_s   = 1'b1;
          end else begin
            idx_s   = idx_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            txd_s   = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == STOP_LAST) begin
          cnt_s = '0;
          if (level_r != '0) begin
            pop_s   = 1'b1;
            state_s = START;
            shift_s = mem_r[rd_ptr_r];
            txd_s   = 1'b0;
          end else begin
            state_s = IDLE;
            txd_s   = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
      end
    endcase
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
  end

  // FSM, pointers and registered outputs; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= 3'd0;
      shift_r  <= 8'd0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      level_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      txd_r    <= txd_s;
      busy_r   <= (state_s != IDLE) || (level_s != '0);
      ready_r  <= (level_s != LEVEL_FULL);
      level_r  <= level_s;
      wr_ptr_r <= push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
    end
  end

  // FIFO storage; contents need no reset because the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= tx_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: one instance with 1 stop bit and one with 2, each compared every
// cycle against a frame-timing reference model (byte queue plus bit position from frame start).
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       vld0, vld1;
  logic [7:0] dat0, dat1;
  logic       rdy0, rdy1, txd0, txd1, busy0, busy1;
  logic [2:0] lvl0, lvl1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut_sb1 (
    .clk(clk), .reset(reset), .tx_data(dat0), .tx_valid(vld0), .tx_ready(rdy0),
    .txd(txd0), .busy(busy0), .fifo_level(lvl0));

  uart_tx_fifo #(.CLK_DIV(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut_sb2 (
    .clk(clk), .reset(reset), .tx_data(dat1), .tx_valid(vld1), .tx_ready(rdy1),
    .txd(txd1), .busy(busy1), .fifo_level(lvl1));

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  // Reference model state per instance: byte queue as a ring, current frame start edge
  logic [7:0] m_buf [2][8];
  int         m_head [2];
  int         m_cnt [2];
  int         m_fstart [2];
  logic       m_active [2];
  logic       m_ready [2];
  logic [7:0] m_cur [2];

  // Producer: bytes to send, per-instance read index, valid held until accepted
  logic [7:0] script [$];
  int         rd [2];
  logic       offered [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, ecnt, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return (9 + ((i == 0) ? 1 : 2)) * C;
  endfunction

  function automatic logic exp_txd(input int i);
    int k;
    if (!m_active[i]) return 1'b1;
    k = ecnt - m_fstart[i];
    if (k < C) return 1'b0;
    if (k < 9 * C) return m_cur[i][(k / C) - 1];
    return 1'b1;
  endfunction

  task automatic model_edge(input int i, input logic rst, input logic push, input logic [7:0] b);
    if (rst) begin
      m_cnt[i] = 0; m_head[i] = 0; m_active[i] = 1'b0; m_ready[i] = 1'b0;
    end else begin
      if (m_active[i] && (ecnt == m_fstart[i] + frame_len(i))) m_active[i] = 1'b0;
      if (!m_active[i] && (m_cnt[i] > 0)) begin
        m_cur[i]    = m_buf[i][m_head[i]];
        m_head[i]   = (m_head[i] + 1) % 8;
        m_cnt[i]--;
        m_active[i] = 1'b1;
        m_fstart[i] = ecnt;
      end
      if (push) begin
        m_buf[i][(m_head[i] + m_cnt[i]) % 8] = b;
        m_cnt[i]++;
      end
      m_ready[i] = (m_cnt[i] != DEPTH);
    end
  endtask

  task automatic step(input logic rst, input int offer_pct);
    logic       acc;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      if (!offered[i] && (rd[i] < script.size()) && ($urandom_range(99) < offer_pct))
        offered[i] = 1'b1;
    end
    vld0  = offered[0];
    dat0  = offered[0] ? script[rd[0]] : 8'bx;
    vld1  = offered[1];
    dat1  = offered[1] ? script[rd[1]] : 8'bx;
    reset = rst;
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      acc = !rst && offered[i] && m_ready[i];
      b   = acc ? script[rd[i]] : 8'd0;
      model_edge(i, rst, acc, b);
      if (acc) begin
        offered[i] = 1'b0;
        rd[i]++;
      end
    end
    #1;
    check_eq("txd_sb1",   int'(txd0),  int'(exp_txd(0)));
    check_eq("busy_sb1",  int'(busy0), int'(m_active[0] || (m_cnt[0] > 0)));
    check_eq("level_sb1", int'(lvl0),  m_cnt[0]);
    check_eq("ready_sb1", int'(rdy0),  int'(m_ready[0]));
    check_eq("txd_sb2",   int'(txd1),  int'(exp_txd(1)));
    check_eq("busy_sb2",  int'(busy1), int'(m_active[1] || (m_cnt[1] > 0)));
    check_eq("level_sb2", int'(lvl1),  m_cnt[1]);
    check_eq("ready_sb2", int'(rdy1),  int'(m_ready[1]));
  endtask

  initial begin
    int guard;
    reset = 1'b1; vld0 = 1'b0; vld1 = 1'b0; dat0 = 8'd0; dat1 = 8'd0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; offered[i] = 1'b0; m_cnt[i] = 0; m_head[i] = 0;
      m_active[i] = 1'b0; m_ready[i] = 1'b0; m_fstart[i] = 0; m_cur[i] = 8'd0;
    end

    // Reset held 5 clocks, then idle
    for (int k = 0; k < 5; k++) step(1'b1, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 0);

    // Single byte into an idle transmitter
    script.push_back(8'h55);
    for (int k = 0; k < 60; k++) step(1'b0, 100);

    // Back-to-back burst overrunning the FIFO
    script.push_back(8'h00); script.push_back(8'hFF); script.push_back(8'hA5);
    script.push_back(8'h3C); script.push_back(8'h81);
    for (int k = 0; k < 260; k++) step(1'b0, 100);

    // Two-byte pair (stop-bit spacing visible on the 2-stop instance)
    script.push_back(8'h01); script.push_back(8'h02);
    for (int k = 0; k < 110; k++) step(1'b0, 100);

    // Reset in the middle of data bit 3 with bytes still queued
    script.push_back(8'hC3); script.push_back(8'h5A); script.push_back(8'h96);
    guard = 0;
    while (!(m_active[0] && (ecnt - m_fstart[0] == 17)) && (guard < 200)) begin
      step(1'b0, 100);
      guard++;
    end
    check_eq("midframe_window_reached", int'(guard < 200), 1);
    step(1'b1, 100);
    for (int k = 0; k < 60; k++) step(1'b0, 100);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      if ((script.size() - rd[0] < 2) || (script.size() - rd[1] < 2))
        script.push_back(8'($urandom_range(255)));
      step(($urandom_range(599) == 0) ? 1'b1 : 1'b0, 30);
    end
    for (int k = 0; k < 120; k++) step(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
